// File: rtl/mem_cmd_arbiter_if.sv
// Command bus between the two requesters, the MCB command port and the arbiter.
// The master modport is the requester/MCB side; the arbiter connects through slave.
interface mem_cmd_arbiter_if;
  logic        calib_done;
  logic        req0;
  logic        req1;
  logic [2:0]  instr0;
  logic [2:0]  instr1;
  logic [5:0]  bl0;
  logic [5:0]  bl1;
  logic [29:0] addr0;
  logic [29:0] addr1;
  logic        ack0;
  logic        ack1;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        busy;
  logic        grant_id;

  modport master (
    output calib_done, req0, req1, instr0, instr1, bl0, bl1, addr0, addr1, mem_cmd_full,
    input  ack0, ack1, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, busy, grant_id
  );

  modport slave (
    input  calib_done, req0, req1, instr0, instr1, bl0, bl1, addr0, addr1, mem_cmd_full,
    output ack0, ack1, mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, busy, grant_id
  );
endinterface

// File: rtl/mem_cmd_arbiter.sv
// Two-requester arbiter feeding the MCB command port; round-robin on ties.
// Define MEM_ARB_FIXED_PRIO_EN to make requester 0 always win a tie instead.
module mem_cmd_arbiter (
  input logic               clk,
  input logic               rst_n,
  mem_cmd_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant_go;
  logic        issue_go;
  logic        winner;
  logic        busy_c;

  logic        en_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        grant_q;
  logic [2:0]  instr_q;
  logic [5:0]  bl_q;
  logic [29:0] addr_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic        last_grant;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.calib_done && (bus.req0 || bus.req1)) state_nxt = ISSUE;
      ISSUE:   if (!bus.mem_cmd_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state == ISSUE);
    grant_go = (state == IDLE) && bus.calib_done && (bus.req0 || bus.req1);
    issue_go = (state == ISSUE) && !bus.mem_cmd_full;
`ifdef MEM_ARB_FIXED_PRIO_EN
    winner   = !bus.req0;
`else
    // A lone request wins outright; on a tie the side not granted last wins.
    winner   = bus.req1 && (!bus.req0 || !last_grant);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      grant_q    <= 1'b0;
      instr_q    <= '0;
      bl_q       <= '0;
      addr_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      en_q   <= issue_go;
      ack0_q <= issue_go && !grant_q;
      ack1_q <= issue_go && grant_q;
      if (grant_go) begin
        grant_q <= winner;
        instr_q <= winner ? bus.instr1 : bus.instr0;
        bl_q    <= winner ? bus.bl1    : bus.bl0;
        addr_q  <= winner ? bus.addr1  : bus.addr0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant <= winner;
`endif
      end
    end
  end

  assign bus.mem_cmd_en        = en_q;
  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.grant_id          = grant_q;
  assign bus.mem_cmd_instr     = instr_q;
  assign bus.mem_cmd_bl        = bl_q;
  assign bus.mem_cmd_byte_addr = addr_q;
  assign bus.busy              = busy_c;
endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Bench for mem_cmd_arbiter: directed scenarios plus random traffic scored against
// a transaction-level model of the arbiter (pending command record + tie rule).
module tb_mem_cmd_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_cmd_arbiter_if bus();

  mem_cmd_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit        id;
    bit [2:0]  instr;
    bit [5:0]  bl;
    bit [29:0] addr;
  } cmd_t;

  // Model: a command is either pending in the arbiter or not; one issue per pending command.
  bit   m_pend;
  cmd_t m_cmd;
  int   m_last;
  bit   m_en;

  task automatic model_reset();
    m_pend = 0;
    m_cmd  = '{id: 0, instr: 0, bl: 0, addr: 0};
    m_last = 1;
    m_en   = 0;
  endtask

  task automatic idle_inputs();
    bus.calib_done   = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.instr0 = '0; bus.instr1 = '0;
    bus.bl0 = '0;    bus.bl1 = '0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.mem_cmd_full = 1'b0;
  endtask

  task automatic step();
    bit        calib, r0, r1, full;
    cmd_t      c0, c1;
    int        w;
    calib = bus.calib_done; r0 = bus.req0; r1 = bus.req1; full = bus.mem_cmd_full;
    c0 = '{id: 0, instr: bus.instr0, bl: bus.bl0, addr: bus.addr0};
    c1 = '{id: 1, instr: bus.instr1, bl: bus.bl1, addr: bus.addr1};
    @(posedge clk);
    #1;
    m_en = 0;
    if (m_pend) begin
      if (!full) begin
        m_en   = 1;
        m_pend = 0;
      end
    end else if (calib && (r0 || r1)) begin
      if (r0 && r1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = 1 - m_last;
`endif
      end else begin
        w = r0 ? 0 : 1;
      end
      m_cmd  = (w == 0) ? c0 : c1;
      m_last = w;
      m_pend = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy});
    end
    total++;
    if ({bus.grant_id, bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr} !== 40'd0) begin
      bad++;
      $display("FAIL reset_fields: got %h want 0", {bus.grant_id, bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr});
    end
    bus.req0 = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_calib_gate();
    bus.calib_done = 1'b0;
    bus.req0  = 1'b1;
    bus.addr0 = 30'h0ABC_1230;
    bus.instr0 = 3'd1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (bus.mem_cmd_en !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL calib_hold: cycle %0d got en=%b busy=%b want 0 0", i, bus.mem_cmd_en, bus.busy);
      end
    end
    bus.calib_done = 1'b1;
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL calib_grant: got en=%b busy=%b want 0 1", bus.mem_cmd_en, bus.busy);
    end
    bus.req0 = 1'b0;
    step();
    total++;
    if ({bus.mem_cmd_en, bus.ack0, bus.ack1} !== 3'b110) begin
      bad++;
      $display("FAIL calib_issue: got en/ack0/ack1=%b want 110", {bus.mem_cmd_en, bus.ack0, bus.ack1});
    end
    total++;
    if (bus.mem_cmd_byte_addr !== 30'h0ABC_1230 || bus.mem_cmd_instr !== 3'd1) begin
      bad++;
      $display("FAIL calib_fields: got addr=%h instr=%0d want 0abc1230 1", bus.mem_cmd_byte_addr, bus.mem_cmd_instr);
    end
    step();
  endtask

  task automatic test_fields();
    bus.req0   = 1'b1;
    bus.addr0  = 30'h0020_0100;
    bus.bl0    = 6'd63;
    bus.instr0 = 3'd0;
    step();
    bus.req0  = 1'b0;
    bus.addr0 = 30'h3FFF_FFFF;
    bus.bl0   = 6'd5;
    bus.instr0 = 3'd7;
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b1 || bus.ack0 !== 1'b1) begin
      bad++;
      $display("FAIL fields_strobe: got en=%b ack0=%b want 1 1", bus.mem_cmd_en, bus.ack0);
    end
    total++;
    if (bus.mem_cmd_byte_addr !== 30'h0020_0100 || bus.mem_cmd_bl !== 6'd63 || bus.mem_cmd_instr !== 3'd0) begin
      bad++;
      $display("FAIL fields_value: got addr=%h bl=%0d instr=%0d want 00200100 63 0",
               bus.mem_cmd_byte_addr, bus.mem_cmd_bl, bus.mem_cmd_instr);
    end
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b0 || bus.ack0 !== 1'b0) begin
      bad++;
      $display("FAIL fields_single: got en=%b ack0=%b want 0 0", bus.mem_cmd_en, bus.ack0);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    bit prev_en;
    test_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.addr0 = 30'h100;
    bus.addr1 = 30'h200;
    prev_en = 0;
    for (int i = 0; i < 40 && grants.size() < 8; i++) begin
      step();
      if (bus.ack0 === 1'b1) grants.push_back(0);
      if (bus.ack1 === 1'b1) grants.push_back(1);
      total++;
      if ((bus.ack0 && bus.ack1) || (prev_en && bus.mem_cmd_en)) begin
        bad++;
        $display("FAIL rr_pulse: cycle %0d got ack0=%b ack1=%b en=%b prev_en=%b want single pulses",
                 i, bus.ack0, bus.ack1, bus.mem_cmd_en, prev_en);
      end
      prev_en = bus.mem_cmd_en;
    end
    total++;
    if (grants.size() != 8) begin
      bad++;
      $display("FAIL rr_count: got %0d want 8", grants.size());
    end
    foreach (grants[k]) begin
      int exp;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = k % 2;
`endif
      total++;
      if (grants[k] != exp) begin
        bad++;
        $display("FAIL rr_order: grant %0d got %0d want %0d", k, grants[k], exp);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_full_stall();
    bus.mem_cmd_full = 1'b1;
    bus.req1  = 1'b1;
    bus.addr1 = 30'h0123_4560;
    step();
    bus.req1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (bus.mem_cmd_en !== 1'b0 || bus.busy !== 1'b1 || bus.mem_cmd_byte_addr !== 30'h0123_4560) begin
        bad++;
        $display("FAIL full_hold: cycle %0d got en=%b busy=%b addr=%h want 0 1 01234560",
                 i, bus.mem_cmd_en, bus.busy, bus.mem_cmd_byte_addr);
      end
    end
    bus.mem_cmd_full = 1'b0;
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b1 || bus.ack1 !== 1'b1 || bus.grant_id !== 1'b1) begin
      bad++;
      $display("FAIL full_release: got en=%b ack1=%b gid=%b want 1 1 1", bus.mem_cmd_en, bus.ack1, bus.grant_id);
    end
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL full_after: got en=%b busy=%b want 0 0", bus.mem_cmd_en, bus.busy);
    end
  endtask

  task automatic test_field_hold();
    bus.req1  = 1'b1;
    bus.addr1 = 30'h1111_2220;
    bus.bl1   = 6'd17;
    step();
    bus.addr1 = 30'h2222_3330;
    bus.bl1   = 6'd40;
    bus.req1  = 1'b0;
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b1 || bus.mem_cmd_byte_addr !== 30'h1111_2220 || bus.mem_cmd_bl !== 6'd17) begin
      bad++;
      $display("FAIL hold_addr: got en=%b addr=%h bl=%0d want 1 11112220 17",
               bus.mem_cmd_en, bus.mem_cmd_byte_addr, bus.mem_cmd_bl);
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    bus.mem_cmd_full = 1'b1;
    bus.req0  = 1'b1;
    bus.addr0 = 30'h0F0F_0F00;
    bus.bl0   = 6'd9;
    bus.instr0 = 3'd3;
    step();
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: got busy=%b want 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy, bus.grant_id, bus.mem_cmd_instr,
         bus.mem_cmd_bl, bus.mem_cmd_byte_addr} !== 44'd0) begin
      bad++;
      $display("FAIL rst_mid_now: got %h want 0", {bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy,
               bus.grant_id, bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr});
    end
    bus.mem_cmd_full = 1'b0;
    bus.req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.mem_cmd_en !== 1'b0 || bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_hold: cycle %0d got en=%b ack0=%b busy=%b want 0 0 0",
                 i, bus.mem_cmd_en, bus.ack0, bus.busy);
      end
    end
    rst_n = 1'b1;
    model_reset();
    step();
    total++;
    if (bus.mem_cmd_en !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after: got en=%b busy=%b want 0 0", bus.mem_cmd_en, bus.busy);
    end
  endtask

  task automatic test_random();
    bit prev_en;
    prev_en = 0;
    for (int i = 0; i < 400; i++) begin
      bus.calib_done   = ($urandom_range(7) != 0);
      bus.req0         = $urandom_range(1);
      bus.req1         = $urandom_range(1);
      bus.mem_cmd_full = ($urandom_range(9) < 3);
      bus.instr0 = 3'($urandom);  bus.instr1 = 3'($urandom);
      bus.bl0    = 6'($urandom);  bus.bl1    = 6'($urandom);
      bus.addr0  = 30'($urandom); bus.addr1  = 30'($urandom);
      step();
      total++;
      if ({bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy} !==
          {m_en, m_en && !m_cmd.id, m_en && m_cmd.id, m_pend}) begin
        bad++;
        $display("FAIL rand_ctrl: cycle %0d got en/ack0/ack1/busy=%b want %b", i,
                 {bus.mem_cmd_en, bus.ack0, bus.ack1, bus.busy},
                 {m_en, m_en && !m_cmd.id, m_en && m_cmd.id, m_pend});
      end
      total++;
      if ({bus.grant_id, bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr} !==
          {m_cmd.id, m_cmd.instr, m_cmd.bl, m_cmd.addr}) begin
        bad++;
        $display("FAIL rand_fields: cycle %0d got %h want %h", i,
                 {bus.grant_id, bus.mem_cmd_instr, bus.mem_cmd_bl, bus.mem_cmd_byte_addr},
                 {m_cmd.id, m_cmd.instr, m_cmd.bl, m_cmd.addr});
      end
      total++;
      if ((bus.ack0 && bus.ack1) || (prev_en && bus.mem_cmd_en)) begin
        bad++;
        $display("FAIL rand_pulse: cycle %0d got ack0=%b ack1=%b en=%b prev_en=%b want single pulses",
                 i, bus.ack0, bus.ack1, bus.mem_cmd_en, prev_en);
      end
      prev_en = bus.mem_cmd_en;
    end
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    test_reset();
    test_calib_gate();
    test_fields();
    test_round_robin();
    test_full_stall();
    test_field_hold();
    test_reset_mid_issue();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
